procyon_lsu_ex_v2: RTL and testbench
====================================

// Module: procyon_lsu_ex_v2
// PURPOSE
//  LSU execute stage, second generation: sits between the dcache lookup stage and CDB/LQ/SQ update.
//  Extracts and extends load data at any byte offset, flags misaligned accesses, and supports LBU/LHU.
//  Queues dirty fill victims in a small FIFO drained via valid/ready, with backpressure to the LSU.
// PARAMETERS
//  OPTN_DATA_WIDTH     32  data word width in bits; power of 2, >=32
//  OPTN_ADDR_WIDTH     32  address width
//  OPTN_LQ_DEPTH       8   LQ entries (one-hot select width)
//  OPTN_SQ_DEPTH       8   SQ entries (one-hot select width)
//  OPTN_DC_LINE_SIZE   32  dcache line size in bytes
//  OPTN_ROB_IDX_WIDTH  5   ROB tag width
//  OPTN_VQ_DEPTH       2   victim FIFO entries; >=1
//  DC_LINE_WIDTH       OPTN_DC_LINE_SIZE*8 (derived)
// PORTS
//  clk                 in   1          clock
//  rst                 in   1          synchronous reset, active-high
//  i_flush             in   1          pipeline flush
//  i_valid             in   1          op valid this cycle
//  i_lsu_func          in   FUNC_W     PCYN_LSU_FUNC_{LB,LH,LW,LBU,LHU,SB,SH,SW,FILL}
//  i_lq_select/i_sq_select in LQ/SQ_DEPTH  one-hot entry select
//  i_tag               in   ROB_IDX_W  ROB tag
//  i_addr              in   ADDR_W     byte address
//  i_retire            in   1          op is a retiring store
//  i_dc_hit            in   1          dcache hit
//  i_dc_data           in   DATA_W     aligned dcache word
//  i_dc_victim_valid/_dirty in 1      fill evicts a valid/dirty line
//  i_dc_victim_addr/_data   in ADDR_W/LINE_W  victim line address/data
//  o_valid/o_data/o_addr/o_tag  out 1/DATA_W/ADDR_W/ROB_IDX_W  CDB broadcast
//  o_misaligned        out  1          qualifies o_valid: access misaligned
//  o_update_lq_en/_select/_retry  out 1/LQ_DEPTH/1  LQ update
//  o_update_sq_en/_select/_retry  out 1/SQ_DEPTH/1  SQ update
//  o_fill_retry        out  1          dirty-victim fill dropped, LSU must replay
//  o_stall             out  1          victim FIFO full; LSU must not issue FILL
//  o_victim_valid/_addr/_data out 1/ADDR_W/LINE_W  victim FIFO head
//  i_victim_ready      in   1          victim consumer accepts head
// BEHAVIOUR
//  - Reset: all o_*_en, o_valid, o_misaligned, o_fill_retry, o_victim_valid = 0; FIFO empty, o_stall=0.
//    Data/select/tag/addr registers are not reset.
//  - Latency 1: all CDB/LQ/SQ outputs are registered from same-cycle inputs.
//  - Offset off = i_addr[log2(DATA_W/8)-1:0]; shifted = i_dc_data >> (8*off).
//  - LB/LH: sign-extend shifted[7:0]/[15:0]. LBU/LHU: zero-extend. LW: shifted.
//  - Misaligned: LH/LHU/SH with off[0]!=0; LW/SW with off[1:0]!=0.
//  - o_valid <= ~flush & valid & ~FILL & ~retire & (hit | store | misaligned); o_misaligned <= the same & misaligned.
//  - o_data <= 0 when misaligned.
//  - o_update_lq_en <= ~flush & valid & load; lq_retry <= ~hit & ~misaligned.
//  - o_update_sq_en <= ~flush & valid & retire; sq_retry <= ~hit.
//  - Victim enqueue when valid & FILL & victim_valid & victim_dirty (i_flush ignored: dirty data is never lost).
//  - Enqueue accepted if count<VQ_DEPTH, or count==VQ_DEPTH with a dequeue the same cycle.
//  - Otherwise the victim is dropped and o_fill_retry=1 next cycle (1-cycle pulse).
//  - Dequeue on o_victim_valid & i_victim_ready. Simultaneous enq+deq leaves count unchanged.
//  - Pointers wrap modulo VQ_DEPTH. Head/valid are registered.
//  - o_stall = (count==VQ_DEPTH), a decode of the registered count.
//  - rst mid-operation empties the FIFO; pending victims are discarded.
// TESTING
//  - LBU at addr 0x1003, dc_data 0x80FF_1234 -> next cycle o_valid=1, o_data=0x0000_0080.
//  - LH at addr 0x1002, dc_data 0x8001_0000 -> o_data=0xFFFF_8001.
//  - LW at addr 0x1001, hit -> o_valid=1, o_misaligned=1, o_data=0, lq_en=1, lq_retry=0.
//  - Load miss, i_flush=1 same cycle -> o_valid=0, lq_en=0. The same miss without flush -> lq_en=1, lq_retry=1.
//  - VQ_DEPTH=2, three dirty fills with ready=0 -> o_stall=1 after 2nd, o_fill_retry pulse after 3rd, FIFO order preserved.
//  - FIFO full, dirty fill with ready=1 same cycle -> accepted, count stays 2.
//  - Assert rst with 2 queued -> o_victim_valid=0 next cycle.

Source files
------------

// File: rtl/procyon_lsu_ex_v2.sv
// procyon_lsu_ex_v2: LSU execute stage. Aligns and extends load data,
// flags misaligned accesses, forms CDB/LQ/SQ updates one cycle after the
// dcache lookup, and buffers dirty fill victims in a small FIFO.
module procyon_lsu_ex_v2 #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_LQ_DEPTH      = 8,
  parameter int OPTN_SQ_DEPTH      = 8,
  parameter int OPTN_DC_LINE_SIZE  = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_VQ_DEPTH      = 2,
  localparam int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8,
  localparam int FUNC_W            = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_flush,
  input  logic                          i_valid,
  input  logic [FUNC_W-1:0]             i_lsu_func,
  input  logic [OPTN_LQ_DEPTH-1:0]      i_lq_select,
  input  logic [OPTN_SQ_DEPTH-1:0]      i_sq_select,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_addr,
  input  logic                          i_retire,
  input  logic                          i_dc_hit,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_dc_data,
  input  logic                          i_dc_victim_valid,
  input  logic                          i_dc_victim_dirty,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_dc_victim_addr,
  input  logic [DC_LINE_WIDTH-1:0]      i_dc_victim_data,
  output logic                          o_valid,
  output logic [OPTN_DATA_WIDTH-1:0]    o_data,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_addr,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_tag,
  output logic                          o_misaligned,
  output logic                          o_update_lq_en,
  output logic [OPTN_LQ_DEPTH-1:0]      o_update_lq_select,
  output logic                          o_update_lq_retry,
  output logic                          o_update_sq_en,
  output logic [OPTN_SQ_DEPTH-1:0]      o_update_sq_select,
  output logic                          o_update_sq_retry,
  output logic                          o_fill_retry,
  output logic                          o_stall,
  output logic                          o_victim_valid,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_victim_addr,
  output logic [DC_LINE_WIDTH-1:0]      o_victim_data,
  input  logic                          i_victim_ready
);

  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_LB   = 4'd0;
  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_LH   = 4'd1;
  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_LW   = 4'd2;
  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_LBU  = 4'd3;
  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_LHU  = 4'd4;
  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_SB   = 4'd5;
  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_SH   = 4'd6;
  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_SW   = 4'd7;
  localparam logic [FUNC_W-1:0] PCYN_LSU_FUNC_FILL = 4'd8;

  localparam int OFF_W = $clog2(OPTN_DATA_WIDTH / 8);
  localparam int PTR_W = (OPTN_VQ_DEPTH > 1) ? $clog2(OPTN_VQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(OPTN_VQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] VQ_FULL  = CNT_W'(OPTN_VQ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OPTN_VQ_DEPTH - 1);

  logic [OFF_W-1:0]           off;
  logic [OPTN_DATA_WIDTH-1:0] shifted;
  logic [OPTN_DATA_WIDTH-1:0] load_data;
  logic                       is_load;
  logic                       is_store;
  logic                       is_fill;
  logic                       misaligned;
  logic                       cdb_valid;

  logic [OPTN_ADDR_WIDTH-1:0] vq_addr [OPTN_VQ_DEPTH];
  logic [DC_LINE_WIDTH-1:0]   vq_data [OPTN_VQ_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_next;
  logic                       enq_req;
  logic                       enq;
  logic                       deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign off     = i_addr[OFF_W-1:0];
  assign shifted = i_dc_data >> {off, 3'b000};

  // Decode the operation class, alignment and extended load result
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_fill    = 1'b0;
    misaligned = 1'b0;
    load_data  = shifted;
    case (i_lsu_func)
      PCYN_LSU_FUNC_LB: begin
        is_load   = 1'b1;
        load_data = {{(OPTN_DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      end
      PCYN_LSU_FUNC_LH: begin
        is_load    = 1'b1;
        misaligned = off[0];
        load_data  = {{(OPTN_DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      end
      PCYN_LSU_FUNC_LW: begin
        is_load    = 1'b1;
        misaligned = |off[1:0];
      end
      PCYN_LSU_FUNC_LBU: begin
        is_load   = 1'b1;
        load_data = {{(OPTN_DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      end
      PCYN_LSU_FUNC_LHU: begin
        is_load    = 1'b1;
        misaligned = off[0];
        load_data  = {{(OPTN_DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      end
      PCYN_LSU_FUNC_SB: is_store = 1'b1;
      PCYN_LSU_FUNC_SH: begin
        is_store   = 1'b1;
        misaligned = off[0];
      end
      PCYN_LSU_FUNC_SW: begin
        is_store   = 1'b1;
        misaligned = |off[1:0];
      end
      PCYN_LSU_FUNC_FILL: is_fill = 1'b1;
      default: ;
    endcase
  end

  assign cdb_valid = ~i_flush & i_valid & ~is_fill & ~i_retire &
                     (i_dc_hit | is_store | misaligned);

  // Control outputs: cleared on reset, qualify the unreset payload below
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid        <= 1'b0;
      o_misaligned   <= 1'b0;
      o_update_lq_en <= 1'b0;
      o_update_sq_en <= 1'b0;
    end else begin
      o_valid        <= cdb_valid;
      o_misaligned   <= cdb_valid & misaligned;
      o_update_lq_en <= ~i_flush & i_valid & is_load;
      o_update_sq_en <= ~i_flush & i_valid & i_retire;
    end
  end

  // Payload registers; only meaningful when the matching enable is set
  always_ff @(posedge clk) begin
    o_data             <= misaligned ? '0 : load_data;
    o_addr             <= i_addr;
    o_tag              <= i_tag;
    o_update_lq_select <= i_lq_select;
    o_update_lq_retry  <= ~i_dc_hit & ~misaligned;
    o_update_sq_select <= i_sq_select;
    o_update_sq_retry  <= ~i_dc_hit;
  end

  // A full FIFO can still take a victim when the head leaves this cycle
  assign enq_req = i_valid & is_fill & i_dc_victim_valid & i_dc_victim_dirty;
  assign deq     = o_victim_valid & i_victim_ready;
  assign enq     = enq_req & ((count != VQ_FULL) | deq);

  // Occupancy after this cycle's enqueue/dequeue
  always_comb begin
    count_next = count;
    if (enq & ~deq) begin
      count_next = count + CNT_W'(1);
    end else if (~enq & deq) begin
      count_next = count - CNT_W'(1);
    end
  end

  // FIFO pointers, occupancy, registered head-valid and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_victim_valid <= 1'b0;
      o_fill_retry   <= 1'b0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      count          <= count_next;
      o_victim_valid <= (count_next != '0);
      o_fill_retry   <= enq_req & ~enq;
    end
  end

  // Victim storage
  always_ff @(posedge clk) begin
    if (enq) begin
      vq_addr[wr_ptr] <= i_dc_victim_addr;
      vq_data[wr_ptr] <= i_dc_victim_data;
    end
  end

  assign o_stall       = (count == VQ_FULL);
  assign o_victim_addr = vq_addr[rd_ptr];
  assign o_victim_data = vq_data[rd_ptr];

endmodule

// File: tb/tb_procyon_lsu_ex_v2.sv
// Bench for procyon_lsu_ex_v2: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_procyon_lsu_ex_v2;

  localparam int VQD = 2;
  localparam logic [3:0] F_LB = 4'd0, F_LH = 4'd1, F_LW = 4'd2, F_LBU = 4'd3,
                         F_LHU = 4'd4, F_SB = 4'd5, F_SH = 4'd6, F_SW = 4'd7,
                         F_FILL = 4'd8;

  logic         clk, rst, i_flush, i_valid, i_retire, i_dc_hit;
  logic [3:0]   i_lsu_func;
  logic [7:0]   i_lq_select, i_sq_select;
  logic [4:0]   i_tag;
  logic [31:0]  i_addr, i_dc_data;
  logic         i_dc_victim_valid, i_dc_victim_dirty, i_victim_ready;
  logic [31:0]  i_dc_victim_addr;
  logic [255:0] i_dc_victim_data;
  logic         o_valid, o_misaligned, o_update_lq_en, o_update_lq_retry;
  logic         o_update_sq_en, o_update_sq_retry, o_fill_retry, o_stall, o_victim_valid;
  logic [31:0]  o_data, o_addr, o_victim_addr;
  logic [4:0]   o_tag;
  logic [7:0]   o_update_lq_select, o_update_sq_select;
  logic [255:0] o_victim_data;

  procyon_lsu_ex_v2 #(.OPTN_VQ_DEPTH(VQD)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_lsu_func(i_lsu_func), .i_lq_select(i_lq_select), .i_sq_select(i_sq_select),
    .i_tag(i_tag), .i_addr(i_addr), .i_retire(i_retire), .i_dc_hit(i_dc_hit),
    .i_dc_data(i_dc_data), .i_dc_victim_valid(i_dc_victim_valid),
    .i_dc_victim_dirty(i_dc_victim_dirty), .i_dc_victim_addr(i_dc_victim_addr),
    .i_dc_victim_data(i_dc_victim_data), .o_valid(o_valid), .o_data(o_data),
    .o_addr(o_addr), .o_tag(o_tag), .o_misaligned(o_misaligned),
    .o_update_lq_en(o_update_lq_en), .o_update_lq_select(o_update_lq_select),
    .o_update_lq_retry(o_update_lq_retry), .o_update_sq_en(o_update_sq_en),
    .o_update_sq_select(o_update_sq_select), .o_update_sq_retry(o_update_sq_retry),
    .o_fill_retry(o_fill_retry), .o_stall(o_stall), .o_victim_valid(o_victim_valid),
    .o_victim_addr(o_victim_addr), .o_victim_data(o_victim_data),
    .i_victim_ready(i_victim_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  typedef struct { logic [31:0] a; logic [255:0] d; } victim_t;
  victim_t q[$];
  logic        e_valid, e_mis, e_lq_en, e_lq_retry, e_sq_en, e_sq_retry, e_fill_retry;
  logic [31:0] e_data, e_addr;
  logic [4:0]  e_tag;
  logic [7:0]  e_lq_sel, e_sq_sel;

  // Model: derive next-cycle outputs from the inputs present at each edge
  always @(posedge clk) begin
    int off, v;
    logic [31:0] b;
    bit ld, st, fl, mis, req, acc, dq;
    victim_t nv;
    if (rst) begin
      e_valid = 0; e_mis = 0; e_lq_en = 0; e_sq_en = 0; e_fill_retry = 0;
      q.delete();
    end else begin
      off = int'(i_addr % 4);
      b   = i_dc_data >> (8 * off);
      ld  = (i_lsu_func <= F_LHU);
      st  = (i_lsu_func >= F_SB) && (i_lsu_func <= F_SW);
      fl  = (i_lsu_func == F_FILL);
      mis = 0;
      if (i_lsu_func == F_LH || i_lsu_func == F_LHU || i_lsu_func == F_SH) mis = (off % 2) != 0;
      if (i_lsu_func == F_LW || i_lsu_func == F_SW) mis = (off != 0);
      case (i_lsu_func)
        F_LB:    begin v = int'(b % 256);   if (v > 127)   v -= 256;   end
        F_LH:    begin v = int'(b % 65536); if (v > 32767) v -= 65536; end
        F_LBU:   v = int'(b % 256);
        F_LHU:   v = int'(b % 65536);
        default: v = int'(b);
      endcase
      e_valid    = !i_flush && i_valid && !fl && !i_retire && (i_dc_hit || st || mis);
      e_mis      = e_valid && mis;
      e_data     = mis ? 32'd0 : 32'(v);
      e_addr     = i_addr;
      e_tag      = i_tag;
      e_lq_en    = !i_flush && i_valid && ld;
      e_lq_sel   = i_lq_select;
      e_lq_retry = !i_dc_hit && !mis;
      e_sq_en    = !i_flush && i_valid && i_retire;
      e_sq_sel   = i_sq_select;
      e_sq_retry = !i_dc_hit;
      dq  = (q.size() > 0) && i_victim_ready;
      req = i_valid && fl && i_dc_victim_valid && i_dc_victim_dirty;
      acc = (q.size() < VQD) || dq;
      if (dq) void'(q.pop_front());
      if (req && acc) begin
        nv.a = i_dc_victim_addr;
        nv.d = i_dc_victim_data;
        q.push_back(nv);
      end
      e_fill_retry = req && !acc;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("o_valid", 256'(o_valid), 256'(e_valid));
    chk("o_misaligned", 256'(o_misaligned), 256'(e_mis));
    chk("lq_en", 256'(o_update_lq_en), 256'(e_lq_en));
    chk("sq_en", 256'(o_update_sq_en), 256'(e_sq_en));
    chk("fill_retry", 256'(o_fill_retry), 256'(e_fill_retry));
    chk("victim_valid", 256'(o_victim_valid), 256'(q.size() > 0));
    chk("stall", 256'(o_stall), 256'(q.size() == VQD));
    if (e_valid) begin
      chk("o_data", 256'(o_data), 256'(e_data));
      chk("o_addr", 256'(o_addr), 256'(e_addr));
      chk("o_tag", 256'(o_tag), 256'(e_tag));
    end
    if (e_lq_en) begin
      chk("lq_select", 256'(o_update_lq_select), 256'(e_lq_sel));
      chk("lq_retry", 256'(o_update_lq_retry), 256'(e_lq_retry));
    end
    if (e_sq_en) begin
      chk("sq_select", 256'(o_update_sq_select), 256'(e_sq_sel));
      chk("sq_retry", 256'(o_update_sq_retry), 256'(e_sq_retry));
    end
    if (q.size() > 0) begin
      chk("victim_addr", 256'(o_victim_addr), 256'(q[0].a));
      chk("victim_data", o_victim_data, q[0].d);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    rst = 0; i_flush = 0; i_valid = 0; i_retire = 0; i_dc_hit = 0;
    i_lsu_func = F_LB; i_victim_ready = 0;
    i_dc_victim_valid = 0; i_dc_victim_dirty = 0;
  endtask

  task automatic op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] d, input logic hit);
    idle();
    i_valid = 1; i_lsu_func = f; i_addr = a; i_dc_data = d; i_dc_hit = hit;
    i_tag = 5'd9; i_lq_select = 8'h04; i_sq_select = 8'h10;
  endtask

  task automatic fill(input logic [31:0] a, input logic ready);
    idle();
    i_valid = 1; i_lsu_func = F_FILL; i_dc_victim_valid = 1; i_dc_victim_dirty = 1;
    i_dc_victim_addr = a; i_dc_victim_data = {8{a}}; i_victim_ready = ready;
  endtask

  initial begin
    idle();
    rst = 1; i_addr = 0; i_dc_data = 0; i_tag = 0; i_lq_select = 0; i_sq_select = 0;
    i_dc_victim_addr = 0; i_dc_victim_data = 0;
    step(); step();
    chk("rst_valid", 256'(o_valid), 256'd0);
    chk("rst_victim_valid", 256'(o_victim_valid), 256'd0);
    chk("rst_stall", 256'(o_stall), 256'd0);
    chk("rst_fill_retry", 256'(o_fill_retry), 256'd0);

    op(F_LBU, 32'h1003, 32'h80FF_1234, 1); step();
    chk("lbu_valid", 256'(o_valid), 256'd1);
    chk("lbu_data", 256'(o_data), 256'h80);

    op(F_LH, 32'h1002, 32'h8001_0000, 1); step();
    chk("lh_data", 256'(o_data), 256'hFFFF_8001);

    op(F_LW, 32'h1001, 32'h1234_5678, 1); step();
    chk("lw_mis_valid", 256'(o_valid), 256'd1);
    chk("lw_mis_flag", 256'(o_misaligned), 256'd1);
    chk("lw_mis_data", 256'(o_data), 256'd0);
    chk("lw_mis_lq_en", 256'(o_update_lq_en), 256'd1);
    chk("lw_mis_lq_retry", 256'(o_update_lq_retry), 256'd0);

    op(F_LW, 32'h1000, 32'h5555_AAAA, 0); i_flush = 1; step();
    chk("miss_flush_valid", 256'(o_valid), 256'd0);
    chk("miss_flush_lq_en", 256'(o_update_lq_en), 256'd0);
    op(F_LW, 32'h1000, 32'h5555_AAAA, 0); step();
    chk("miss_lq_en", 256'(o_update_lq_en), 256'd1);
    chk("miss_lq_retry", 256'(o_update_lq_retry), 256'd1);
    chk("miss_valid", 256'(o_valid), 256'd0);

    fill(32'hA100, 0); step();
    chk("f1_stall", 256'(o_stall), 256'd0);
    chk("f1_head", 256'(o_victim_addr), 256'hA100);
    fill(32'hA200, 0); step();
    chk("f2_stall", 256'(o_stall), 256'd1);
    fill(32'hA300, 0); step();
    chk("f3_fill_retry", 256'(o_fill_retry), 256'd1);
    chk("f3_head", 256'(o_victim_addr), 256'hA100);
    fill(32'hA400, 1); step();
    chk("full_enq_deq_retry", 256'(o_fill_retry), 256'd0);
    chk("full_enq_deq_stall", 256'(o_stall), 256'd1);
    chk("full_enq_deq_head", 256'(o_victim_addr), 256'hA200);
    idle(); i_victim_ready = 1; step();
    chk("drain_head", 256'(o_victim_addr), 256'hA400);
    chk("drain_stall", 256'(o_stall), 256'd0);
    idle(); i_victim_ready = 1; step();
    chk("drain_empty", 256'(o_victim_valid), 256'd0);

    fill(32'hB100, 0); step();
    fill(32'hB200, 0); step();
    idle(); rst = 1; step();
    chk("rst_flush_fifo", 256'(o_victim_valid), 256'd0);
    chk("rst_flush_stall", 256'(o_stall), 256'd0);

    for (int n = 0; n < 3000; n++) begin
      rst               = ($urandom_range(0, 199) == 0);
      i_flush           = ($urandom_range(0, 9) == 0);
      i_valid           = ($urandom_range(0, 3) != 0);
      i_lsu_func        = ($urandom_range(0, 3) == 0) ? F_FILL : 4'($urandom_range(0, 7));
      i_addr            = $urandom;
      i_dc_data         = $urandom;
      i_dc_hit          = ($urandom_range(0, 3) != 0);
      i_retire          = ($urandom_range(0, 3) == 0);
      i_tag             = 5'($urandom);
      i_lq_select       = 8'(1 << $urandom_range(0, 7));
      i_sq_select       = 8'(1 << $urandom_range(0, 7));
      i_dc_victim_valid = ($urandom_range(0, 3) != 0);
      i_dc_victim_dirty = ($urandom_range(0, 3) != 0);
      i_dc_victim_addr  = $urandom;
      for (int k = 0; k < 8; k++) i_dc_victim_data[k*32 +: 32] = $urandom;
      i_victim_ready    = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
